// File: rtl/ntt_masked_share_split.sv
// Splits one beat of unmasked GS butterfly operands into two arithmetic shares mod 2^WIDTH
// and buffers them in a 2-entry skid FIFO. Optional recombination check: NTT_MASK_SPLIT_CHECK_EN.
package ntt_masked_share_split_pkg;
    localparam int unsigned MASK_WIDTH = 46;

    typedef enum logic [1:0] {
        MODE_NTT  = 2'd0,
        MODE_INTT = 2'd1,
        MODE_PWM  = 2'd2,
        MODE_ADD  = 2'd3
    } mode_t;

    // Operand order u00, v00, w00, u01, v01, w01; outer index selects the share.
    typedef logic [5:0][MASK_WIDTH-1:0] bf_uvwi_t;
    typedef bf_uvwi_t [1:0] masked_bf_uvwi_t;
endpackage

module ntt_masked_share_split
    import ntt_masked_share_split_pkg::*;
#(
    parameter int unsigned WIDTH      = MASK_WIDTH,
    parameter int unsigned HALF_WIDTH = WIDTH / 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       zeroize,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [HALF_WIDTH-1:0]      u00_i,
    input  logic [HALF_WIDTH-1:0]      v00_i,
    input  logic [HALF_WIDTH-1:0]      w00_i,
    input  logic [HALF_WIDTH-1:0]      u01_i,
    input  logic [HALF_WIDTH-1:0]      v01_i,
    input  logic [HALF_WIDTH-1:0]      w01_i,
    input  logic [5:0][WIDTH-1:0]      rnd_i,
    input  mode_t                      mode_i,
    input  logic                       accumulate_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output masked_bf_uvwi_t            uvw_o,
    output mode_t                      mode_o,
    output logic                       accumulate_o,
    output logic [15:0]                beat_cnt_o,
    output logic                       err_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } fifo_state_t;

    typedef struct packed {
        masked_bf_uvwi_t uvw;
        mode_t           mode;
        logic            acc;
    } entry_t;

    logic [5:0][HALF_WIDTH-1:0] plainOps;
    masked_bf_uvwi_t            newUvw;
    entry_t                     newEntry;
    fifo_state_t                state_q, state_d;
    entry_t                     slot0_q, slot0_d;
    entry_t                     slot1_q, slot1_d;
    logic                       inReady_q, inReady_d;
    logic [15:0]                beatCnt_q, beatCnt_d;
    logic                       accept;
    logic                       pop;

    assign plainOps = {w01_i, v01_i, u01_i, w00_i, v00_i, u00_i};
    assign accept   = in_valid_i && inReady_q;
    assign pop      = (state_q != EMPTY) && out_ready_i;

    // share1 is the raw mask; share0 carries the operand minus the mask.
    always_comb begin
        newUvw = '0;
        for (int k = 0; k < 6; k++) begin
            newUvw[1][k] = rnd_i[k];
            newUvw[0][k] = {{(WIDTH-HALF_WIDTH){1'b0}}, plainOps[k]} - rnd_i[k];
        end
    end

    assign newEntry = '{uvw: newUvw, mode: mode_i, acc: accumulate_i};

    // Slot 0 is always the head; popped slots are wiped so no stale shares linger.
    always_comb begin
        state_d   = state_q;
        slot0_d   = slot0_q;
        slot1_d   = slot1_q;
        beatCnt_d = accept ? beatCnt_q + 16'd1 : beatCnt_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    slot0_d = newEntry;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    slot0_d = newEntry;
                end else if (accept) begin
                    slot1_d = newEntry;
                    state_d = TWO;
                end else if (pop) begin
                    slot0_d = '0;
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    slot0_d = slot1_q;
                    slot1_d = '0;
                    state_d = ONE;
                end
            end
            default: begin
                slot0_d = '0;
                slot1_d = '0;
                state_d = EMPTY;
            end
        endcase
        inReady_d = (state_d != TWO);
        if (zeroize) begin
            state_d   = EMPTY;
            slot0_d   = '0;
            slot1_d   = '0;
            beatCnt_d = '0;
            inReady_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= EMPTY;
            slot0_q   <= '0;
            slot1_q   <= '0;
            inReady_q <= 1'b0;
            beatCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            slot0_q   <= slot0_d;
            slot1_q   <= slot1_d;
            inReady_q <= inReady_d;
            beatCnt_q <= beatCnt_d;
        end
    end

    assign in_ready_o   = inReady_q;
    assign out_valid_o  = (state_q != EMPTY);
    assign uvw_o        = slot0_q.uvw;
    assign mode_o       = slot0_q.mode;
    assign accumulate_o = slot0_q.acc;
    assign beat_cnt_o   = beatCnt_q;

`ifdef NTT_MASK_SPLIT_CHECK_EN
    logic             mismatch;
    logic [WIDTH-1:0] recombined;
    logic             err_q, err_d;

    // Recombine the freshly split shares and compare with the operands they came from.
    always_comb begin
        mismatch   = 1'b0;
        recombined = '0;
        for (int k = 0; k < 6; k++) begin
            recombined = newUvw[0][k] + newUvw[1][k];
            if (recombined != {{(WIDTH-HALF_WIDTH){1'b0}}, plainOps[k]}) begin
                mismatch = 1'b1;
            end
        end
        err_d = zeroize ? 1'b0 : (err_q || (accept && mismatch));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule
